// File: rtl/alu_pkg.sv
// Shared types for the ALU + sequential BCD display path: op encodings, flag
// positions, converter states and the digit-capacity check used at elaboration.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_AND = 4'b0100,
    OP_OR  = 4'b1000
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_e;

  // True when `digits` decimal digits can hold every value of a `bits` wide word.
  function automatic bit bcd_fits(int digits, int bits);
    longint p10;
    longint p2;
    p10 = 64'sd1;
    p2  = 64'sd1;
    for (int i = 0; i < digits; i++) p10 = p10 * 64'sd10;
    for (int i = 0; i < bits; i++) p2 = p2 * 64'sd2;
    return p10 >= p2;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle, BITS cycles per conversion.
// bcd only updates on the final shift, so it never shows partial digits.
module bin2bcd_seq
  import alu_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BITS-1:0]     mag,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                busy,
  output logic                load,
  output conv_state_e         state
);

  localparam int CW = $clog2(BITS + 1);

  conv_state_e         state_q;
  logic [CW-1:0]       cnt_q;
  logic [BITS-1:0]     mag_q;
  logic [4*DIGITS-1:0] work_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] work_adj;
  logic [4*DIGITS-1:0] work_sh;
  logic                done_q;
  logic                busy_q;

  always_comb begin
    work_adj = work_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (work_q[4*d +: 4] >= 4'd5) work_adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
    end
    work_sh = {work_adj[4*DIGITS-2:0], mag_q[BITS-1]};
  end

  assign load = (state_q == CONV_SHIFT) && (cnt_q == CW'(1));

  // start is sampled only in IDLE; done is a one-cycle pulse in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CONV_IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        CONV_IDLE: begin
          if (start) begin
            mag_q   <= mag;
            work_q  <= '0;
            cnt_q   <= CW'(BITS);
            busy_q  <= 1'b1;
            state_q <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          work_q <= work_sh;
          mag_q  <= {mag_q[BITS-2:0], 1'b0};
          cnt_q  <= cnt_q - CW'(1);
          if (load) begin
            bcd_q   <= work_sh;
            done_q  <= 1'b1;
            state_q <= CONV_DONE;
          end
        end
        CONV_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= CONV_IDLE;
        end
        default: state_q <= CONV_IDLE;
      endcase
    end
  end

  assign done  = done_q;
  assign busy  = busy_q;
  assign bcd   = bcd_q;
  assign state = state_q;

endmodule

// File: rtl/alu_bcd_seq.sv
// Registered 4-op ALU with N/Z/C/V flags, button-cycled operation, and a
// signed-magnitude BCD readout refreshed whenever {result, op} changes.
module alu_bcd_seq
  import alu_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                opsel,
  input  logic [BITS-1:0]     vA,
  input  logic [BITS-1:0]     vB,
  output logic [BITS-1:0]     result,
  output logic [3:0]          ALUflags,
  output logic [3:0]          operation,
  output logic [4*DIGITS-1:0] bcd,
  output logic                minus,
  output logic                busy,
  output logic                valid
);

  if (BITS < 2) begin : g_bits_too_small
    $error("alu_bcd_seq: BITS must be at least 2");
  end
  if (!bcd_fits(DIGITS, BITS)) begin : g_digits_too_small
    $error("alu_bcd_seq: DIGITS cannot represent 2**BITS values");
  end

  logic [BITS-1:0] a_q, b_q, res_q, snap_res_q;
  logic [3:0]      flags_q;
  logic [2:0]      sync_q;
  op_e             op_q, res_op_q, snap_op_q;
  logic            force_q, minus_q, minus_pend_q;

  logic [BITS-1:0] b_eff, alu_res, mag;
  logic [BITS:0]   sum;
  logic [3:0]      flags_d;
  logic            cin, c_d, v_d, neg, opsel_rise, start, load, done;
  conv_state_e     conv_state;

  // SUB reuses the adder as A + ~B + 1 so carry means "no borrow".
  always_comb begin
    cin     = (op_q == OP_SUB);
    b_eff   = cin ? ~b_q : b_q;
    sum     = {1'b0, a_q} + {1'b0, b_eff} + {{BITS{1'b0}}, cin};
    alu_res = '0;
    c_d     = 1'b0;
    v_d     = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        alu_res = sum[BITS-1:0];
        c_d     = sum[BITS];
        v_d     = (a_q[BITS-1] == b_eff[BITS-1]) && (alu_res[BITS-1] != a_q[BITS-1]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      default: alu_res = '0;
    endcase
    flags_d         = '0;
    flags_d[FLAG_N] = alu_res[BITS-1];
    flags_d[FLAG_Z] = (alu_res == '0);
    flags_d[FLAG_C] = c_d;
    flags_d[FLAG_V] = v_d;
  end

  assign opsel_rise = sync_q[1] & ~sync_q[2];
  assign neg        = ((res_op_q == OP_ADD) || (res_op_q == OP_SUB)) && res_q[BITS-1];
  assign mag        = neg ? (~res_q + BITS'(1)) : res_q;
  assign start      = (conv_state == CONV_IDLE) &&
                      (force_q || (res_q != snap_res_q) || (res_op_q != snap_op_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      flags_q      <= '0;
      sync_q       <= '0;
      op_q         <= OP_ADD;
      res_op_q     <= OP_ADD;
      snap_res_q   <= '0;
      snap_op_q    <= OP_ADD;
      force_q      <= 1'b1;
      minus_pend_q <= 1'b0;
      minus_q      <= 1'b0;
    end else begin
      a_q      <= vA;
      b_q      <= vB;
      res_q    <= alu_res;
      flags_q  <= flags_d;
      res_op_q <= op_q;
      sync_q   <= {sync_q[1:0], opsel};
      if (opsel_rise) op_q <= op_e'({op_q[2:0], op_q[3]});
      if (start) begin
        snap_res_q   <= res_q;
        snap_op_q    <= res_op_q;
        force_q      <= 1'b0;
        minus_pend_q <= neg;
      end
      if (load) minus_q <= minus_pend_q;
    end
  end

  bin2bcd_seq #(
    .BITS  (BITS),
    .DIGITS(DIGITS)
  ) u_conv (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .mag  (mag),
    .done (done),
    .bcd  (bcd),
    .busy (busy),
    .load (load),
    .state(conv_state)
  );

  assign result    = res_q;
  assign ALUflags  = flags_q;
  assign operation = op_q;
  assign minus     = minus_q;
  assign valid     = done;

endmodule

// File: tb/tb_alu_bcd_seq.sv
// Bench for alu_bcd_seq (BITS=8, DIGITS=3): scenario tasks plus a display
// scoreboard that pops one expected {minus,bcd} per valid pulse.
module tb_alu_bcd_seq;

  localparam int BITS   = 8;
  localparam int DIGITS = 3;

  logic                clk = 1'b0;
  logic                rst, opsel;
  logic [BITS-1:0]     vA, vB, result;
  logic [3:0]          ALUflags, operation;
  logic [4*DIGITS-1:0] bcd;
  logic                minus, busy, valid;

  alu_bcd_seq #(.BITS(BITS), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .opsel(opsel), .vA(vA), .vB(vB),
    .result(result), .ALUflags(ALUflags), .operation(operation),
    .bcd(bcd), .minus(minus), .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [4*DIGITS:0] exp_q[$];
  int cur_a, cur_b, op_idx, last_res, last_op;

  // Reference model: plain integer arithmetic, op index 0..3 = ADD,SUB,AND,OR.
  function automatic logic [11:0] model_alu(int a, int b, int op);
    int s, sa, sb, ss, r;
    logic c, v;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      0: begin s = a + b; r = s % 256; c = (s > 255); ss = sa + sb; v = (ss > 127) || (ss < -128); end
      1: begin s = a - b; r = (s + 256) % 256; c = (a >= b); ss = sa - sb; v = (ss > 127) || (ss < -128); end
      2: r = a & b;
      3: r = a | b;
      default: r = 0;
    endcase
    return {(r >= 128), (r == 0), c, v, 8'(r)};
  endfunction

  function automatic logic [12:0] model_disp(int r, int op);
    int m;
    logic mn;
    if (op < 2 && r >= 128) begin mn = 1'b1; m = 256 - r; end
    else begin mn = 1'b0; m = r; end
    return {mn, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic model_update();
    logic [11:0] x;
    int r;
    x = model_alu(cur_a, cur_b, op_idx);
    r = int'(x[7:0]);
    if (r != last_res || op_idx != last_op) begin
      exp_q.push_back(model_disp(r, op_idx));
      last_res = r;
      last_op  = op_idx;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0 && busy === 1'b0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // Scoreboard monitor; also flags any bcd movement not accompanied by valid.
  initial begin
    logic [4*DIGITS-1:0] prev_bcd;
    logic [4*DIGITS:0]   e;
    prev_bcd = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        prev_bcd = bcd;
      end else begin
        if (bcd !== prev_bcd) begin
          total++;
          if (valid !== 1'b1) begin
            bad++;
            $display("FAIL bcd_glitch: bcd changed %h -> %h without valid", prev_bcd, bcd);
          end
        end
        prev_bcd = bcd;
        if (valid === 1'b1) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid: got minus=%b bcd=%h, none expected", minus, bcd);
          end else begin
            e = exp_q.pop_front();
            if ({minus, bcd} !== e) begin
              bad++;
              $display("FAIL display: got minus=%b bcd=%h, want minus=%b bcd=%h",
                       minus, bcd, e[12], e[11:0]);
            end
          end
        end
      end
    end
  end

  task automatic check_release(input string name);
    int n;
    bit ok;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (valid === 1'b1) break;
    end
    total++;
    if (n != BITS + 1) begin
      bad++;
      $display("FAIL %s latency: got %0d edges, want %0d", name, n, BITS + 1);
    end
    total++;
    if ({operation, ALUflags, result} !== {4'b0001, 4'b0100, 8'h00}) begin
      bad++;
      $display("FAIL %s state: got op=%b flags=%b result=%h, want 0001 0100 00",
               name, operation, ALUflags, result);
    end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s drain: got timeout, want idle", name); end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur_a = 0; cur_b = 0; op_idx = 0; last_res = 0; last_op = 0;
    exp_q.push_back('0);
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1; opsel = 1'b0; vA = '0; vB = '0;
    repeat (3) tick();
    total++;
    if ({result, ALUflags, operation, bcd, minus, busy, valid} !==
        {8'h00, 4'h0, 4'b0001, 12'h000, 3'b000}) begin
      bad++;
      $display("FAIL reset_values: got res=%h fl=%b op=%b bcd=%h m=%b b=%b v=%b",
               result, ALUflags, operation, bcd, minus, busy, valid);
    end
    model_reset();
    rst = 1'b0;
    check_release("reset");
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (valid === 1'b1) cnt++;
    end
    total++;
    if (cnt != 0) begin bad++; $display("FAIL idle_quiet: got %0d valids, want 0", cnt); end
  endtask

  task automatic set_operands(input int a, input int b, input string name);
    logic [11:0] e;
    bit ok;
    vA = 8'(a); vB = 8'(b);
    cur_a = a; cur_b = b;
    model_update();
    e = model_alu(a, b, op_idx);
    tick(); tick();
    total++;
    if ({ALUflags, result} !== e) begin
      bad++;
      $display("FAIL %s alu: got flags=%b result=%h, want flags=%b result=%h",
               name, ALUflags, result, e[11:8], e[7:0]);
    end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s drain: got timeout, want idle", name); end
  endtask

  task automatic press_opsel(input int hold, input string name);
    logic [3:0] old_oh, new_oh;
    bit ok;
    old_oh = 4'(1 << op_idx);
    new_oh = 4'(1 << ((op_idx + 1) % 4));
    opsel = 1'b1;
    tick();
    if (hold <= 1) opsel = 1'b0;
    tick();
    total++;
    if (operation !== old_oh) begin
      bad++; $display("FAIL %s early: got op=%b, want %b", name, operation, old_oh);
    end
    if (hold <= 2) opsel = 1'b0;
    tick();
    total++;
    if (operation !== new_oh) begin
      bad++; $display("FAIL %s advance: got op=%b, want %b", name, operation, new_oh);
    end
    op_idx = (op_idx + 1) % 4;
    model_update();
    for (int i = 3; i < hold; i++) tick();
    opsel = 1'b0;
    repeat (4) tick();
    total++;
    if (operation !== new_oh) begin
      bad++; $display("FAIL %s once: got op=%b, want %b", name, operation, new_oh);
    end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s drain: got timeout, want idle", name); end
  endtask

  task automatic wait_busy(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy === 1'b1) begin seen = 1'b1; break; end
      tick();
    end
    total++;
    if (!seen) begin bad++; $display("FAIL %s busy: got busy=%b, want 1", name, busy); end
  endtask

  task automatic test_add();
    set_operands(200, 100, "add_wrap");
  endtask

  task automatic test_sub();
    press_opsel(1, "to_sub");
    set_operands(5, 9, "sub_neg");
    set_operands(0, 128, "sub_min");
  endtask

  task automatic test_logic_ops();
    press_opsel(20, "held_to_and");
    set_operands(8'hF0, 8'h3C, "and");
    press_opsel(1, "to_or");
    set_operands(8'h80, 8'h01, "or_msb");
    press_opsel(1, "wrap_to_add");
  endtask

  task automatic test_back_to_back();
    bit ok;
    vA = 8'd10; vB = 8'd20; cur_a = 10; cur_b = 20;
    model_update();
    wait_busy("mid_change");
    tick(); tick();
    vA = 8'd50; cur_a = 50;
    model_update();
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL mid_change drain: got timeout, want idle"); end
    total++;
    if (result !== 8'd70) begin
      bad++; $display("FAIL mid_change result: got %h, want %h", result, 8'd70);
    end
  endtask

  task automatic test_reset_mid();
    vA = 8'd33; vB = 8'd44; cur_a = 33; cur_b = 44;
    model_update();
    wait_busy("reset_mid");
    tick(); tick();
    #1 rst = 1'b1;
    #1;
    total++;
    if ({result, ALUflags, operation, bcd, minus, busy, valid} !==
        {8'h00, 4'h0, 4'b0001, 12'h000, 3'b000}) begin
      bad++;
      $display("FAIL reset_mid_values: got res=%h fl=%b op=%b bcd=%h m=%b b=%b v=%b",
               result, ALUflags, operation, bcd, minus, busy, valid);
    end
    vA = '0; vB = '0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    check_release("reset_mid");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_ops();
    test_back_to_back();
    test_reset_mid();
    repeat (5) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover: got %0d pending displays, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
